regfile_wb_sched: RTL and testbench

- Writeback scheduler for the 32x32 register file, which has a single write port (WE3/AD3/WD3).
- Shares that port between two requesters:
  - the ALU result path (single-cycle);
  - the data-memory load-return path (variable latency), buffered in a small FIFO.
- Keeps a load scoreboard and raises a read-hazard stall to the decode stage for source registers whose load has not yet committed.

---
 rtl/regfile_wb_sched_pkg.sv | 21 ++
 rtl/regfile_wb_sched_fifo.sv | 67 ++++++
 rtl/regfile_wb_sched.sv | 155 +++++++++++++++
 tb/tb_regfile_wb_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared CPU package for the register-file writeback path.
//   reg_idx_t : register index (32 registers)
//   word_t    : register data word
//   REG_X0    : the hardwired-zero register index
//   wb_req_t  : a pending writeback {rd, data}
package regfile_wb_sched_pkg;

  localparam int REG_IDX_W = 5;
  localparam int WORD_W    = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [WORD_W-1:0]    word_t;

  localparam reg_idx_t REG_X0 = '0;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t used to buffer load returns.
//   clk, rst    : clock, synchronous active-high reset (clears pointers/count)
//   push        : write push_data this cycle (caller guarantees !full)
//   push_data   : entry to enqueue
//   pop         : drop the head this cycle (caller guarantees !empty)
//   pop_data    : current head (valid while !empty)
//   count       : occupancy, 0..DEPTH
//   full, empty : occupancy flags
// There is no pass-through: a pushed entry is visible at the head one cycle later.
module wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: arbitrates the single register-file write port between
// the ALU result path and a queued load-return path, and keeps a load
// scoreboard that stalls decode on pending load destinations.
//   clk, rst                 : clock, synchronous active-high reset
//   alu_valid/ready/rd/data  : ALU writeback request (accepted when valid && ready)
//   mem_valid/ready/rd/data  : load-return request into the queue
//   ld_issue, ld_rd          : decode issued a load to ld_rd this cycle
//   rs1, rs2                 : decode source registers
//   stall                    : source register has an uncommitted load
//   we3, ad3, wd3            : registered register-file write port
//   mq_count                 : load-return queue occupancy
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MQ_DEPTH      = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDRESS_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDRESS_WIDTH-1:0]   mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       ld_issue,
  input  logic [ADDRESS_WIDTH-1:0]   ld_rd,
  input  logic [ADDRESS_WIDTH-1:0]   rs1,
  input  logic [ADDRESS_WIDTH-1:0]   rs2,
  output logic                       stall,
  output logic                       we3,
  output logic [ADDRESS_WIDTH-1:0]   ad3,
  output logic [DATA_WIDTH-1:0]      wd3,
  output logic [$clog2(MQ_DEPTH):0]  mq_count
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  // Load-return queue
  wb_req_t  mq_push_data;
  wb_req_t  mq_head;
  logic     mq_push;
  logic     mq_full;
  logic     mq_empty;
  logic     grant_alu;
  logic     grant_mem;

  assign mq_push_data = '{rd: mem_rd, data: mem_data};
  assign mem_ready    = !mq_full;
  assign mq_push      = mem_valid && !mq_full;

  wb_fifo #(
    .DEPTH (MQ_DEPTH)
  ) u_mq (
    .clk       (clk),
    .rst       (rst),
    .push      (mq_push),
    .push_data (mq_push_data),
    .pop       (grant_mem),
    .pop_data  (mq_head),
    .count     (mq_count),
    .full      (mq_full),
    .empty     (mq_empty)
  );

  // Arbitration state
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          force_q, force_d;

  // Write port and scoreboard state
  logic                     we3_q, we3_d;
  reg_idx_t                 ad3_q, ad3_d;
  word_t                    wd3_q, wd3_d;
  logic                     src_mem_q, src_mem_d;
  logic [NREG-1:0]          busy_q, busy_d;

  assign alu_ready = !force_q;
  assign grant_alu = !force_q && alu_valid;
  assign grant_mem = !mq_empty && (force_q || !alu_valid);

  // Starvation: count queue losses; reaching the limit forces the next grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_d      = force_q;
    if (mq_empty || grant_mem) starve_cnt_d = '0;
    else                       starve_cnt_d = starve_cnt_q + 1'b1;

    if (force_q && (grant_mem || mq_empty)) force_d = 1'b0;
    else if (starve_cnt_d == SW'(STARVE_LIMIT)) force_d = 1'b1;
  end

  // Commit: register the winner; rd=0 winners are consumed but never written.
  always_comb begin
    we3_d     = 1'b0;
    ad3_d     = ad3_q;
    wd3_d     = wd3_q;
    src_mem_d = 1'b0;
    if (grant_alu) begin
      if (alu_rd != REG_X0) begin
        we3_d = 1'b1;
        ad3_d = alu_rd;
        wd3_d = alu_data;
      end
    end else if (grant_mem) begin
      if (mq_head.rd != REG_X0) begin
        we3_d     = 1'b1;
        ad3_d     = mq_head.rd;
        wd3_d     = mq_head.data;
        src_mem_d = 1'b1;
      end
    end
  end

  // Scoreboard: a load commit clears, a new issue sets; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (we3_q && src_mem_q) busy_d[ad3_q] = 1'b0;
    if (ld_issue && (ld_rd != REG_X0)) busy_d[ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
      we3_q        <= 1'b0;
      ad3_q        <= '0;
      wd3_q        <= '0;
      src_mem_q    <= 1'b0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
      we3_q        <= we3_d;
      ad3_q        <= ad3_d;
      wd3_q        <= wd3_d;
      src_mem_q    <= src_mem_d;
      busy_q       <= busy_d;
    end
  end

  // No bypass: stall holds through the commit cycle and drops the cycle after.
  assign stall = ((rs1 != REG_X0) && busy_q[rs1]) ||
                 ((rs2 != REG_X0) && busy_q[rs2]);

  assign we3 = we3_q;
  assign ad3 = ad3_q;
  assign wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: expected register-file writes are
// queued as stimulus is issued; a negedge monitor pops one per we3 pulse.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        ld_issue;
  logic [4:0]  ld_rd, rs1, rs2;
  logic        stall, we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic [1:0]  mq_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] expq[$];

  always #5 clk = ~clk;

  regfile_wb_sched #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .MQ_DEPTH      (2),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .ld_issue  (ld_issue),
    .ld_rd     (ld_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .stall     (stall),
    .we3       (we3),
    .ad3       (ad3),
    .wd3       (wd3),
    .mq_count  (mq_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    ld_issue  = 1'b0; ld_rd = '0;
  endtask

  // Monitor: every write-port pulse must match the next expected write.
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got ad3=%0d wd3=0x%0h expected no write at %0t", ad3, wd3, $time);
      end else begin
        logic [36:0] e;
        e = expq.pop_front();
        if ({ad3, wd3} !== e) begin
          n_bad++;
          $display("FAIL wb_data: got ad3=%0d wd3=0x%0h expected ad3=%0d wd3=0x%0h at %0t",
                   ad3, wd3, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, mi;
    logic acc_a, acc_m;
    rst = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    repeat (3) tick();
    // Reset state
    chk("rst_we3", we3, 0);
    chk("rst_ad3", ad3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_mq_count", mq_count, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    expq.push_back({5'd5, 32'h1234});
    #1 chk("alu_ready", alu_ready, 1);
    tick(); idle();
    chk("alu_we3", we3, 1);
    chk("alu_ad3", ad3, 5);
    chk("alu_wd3", wd3, 32'h1234);
    tick();

    // Load with scoreboard
    ld_issue = 1; ld_rd = 7; rs1 = 7;
    #1 chk("ld_stall_t0", stall, 0);
    tick(); ld_issue = 0;
    #1 chk("ld_stall_t1", stall, 1);
    tick();
    tick();
    mem_valid = 1; mem_rd = 7; mem_data = 32'hBEEF;
    expq.push_back({5'd7, 32'hBEEF});
    #1 chk("ld_mem_ready", mem_ready, 1);
    tick(); idle();
    chk("ld_stall_t4", stall, 1);
    chk("ld_count_t4", mq_count, 1);
    tick();
    chk("ld_stall_t5", stall, 1);
    chk("ld_we3_t5", we3, 1);
    chk("ld_ad3_t5", ad3, 7);
    tick();
    chk("ld_stall_t6", stall, 0);
    chk("ld_we3_t6", we3, 0);
    rs1 = 0;

    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    mem_valid = 1; mem_rd = 0; mem_data = 32'hCAFE;
    ld_issue = 1; ld_rd = 0;
    tick(); idle();
    chk("x0_we3_a", we3, 0);
    chk("x0_stall", stall, 0);
    tick();
    chk("x0_we3_b", we3, 0);
    tick();
    chk("x0_we3_c", we3, 0);
    chk("x0_count", mq_count, 0);

    // Set/clear collision on x9
    ld_issue = 1; ld_rd = 9; rs1 = 9;
    tick(); idle();
    mem_valid = 1; mem_rd = 9; mem_data = 32'h9999;
    expq.push_back({5'd9, 32'h9999});
    tick(); idle();
    chk("col_stall_pre", stall, 1);
    tick();
    chk("col_we3", we3, 1);
    chk("col_ad3", ad3, 9);
    ld_issue = 1; ld_rd = 9;
    tick(); idle();
    chk("col_stall_kept", stall, 1);
    mem_valid = 1; mem_rd = 9; mem_data = 32'h9A9A;
    expq.push_back({5'd9, 32'h9A9A});
    tick(); idle();
    tick();
    chk("col_we3_2", we3, 1);
    chk("col_stall_commit", stall, 1);
    tick();
    chk("col_stall_clear", stall, 0);
    rs1 = 0;

    // Contention, backpressure and starvation forcing
    for (int k = 0; k < 5; k++)  expq.push_back({5'd10, 32'hA000 + k});
    expq.push_back({5'd11, 32'hB000});
    for (int k = 5; k < 9; k++)  expq.push_back({5'd10, 32'hA000 + k});
    expq.push_back({5'd12, 32'hB001});
    for (int k = 9; k < 13; k++) expq.push_back({5'd10, 32'hA000 + k});
    expq.push_back({5'd13, 32'hB002});
    ai = 0; mi = 0;
    for (int c = 0; c < 16; c++) begin
      alu_valid = (ai < 13); alu_rd = 10; alu_data = 32'hA000 + ai;
      mem_valid = (mi < 3);  mem_rd = 5'(11 + mi); mem_data = 32'hB000 + mi;
      #1;
      chk($sformatf("cont_alu_ready_c%0d", c), alu_ready, (c != 5 && c != 10 && c != 15));
      if (c == 2) begin
        chk("cont_mem_ready_c2", mem_ready, 0);
        chk("cont_count_c2", mq_count, 2);
      end
      if (c == 6) chk("cont_mem_ready_c6", mem_ready, 1);
      if (c == 7) chk("cont_mem_ready_c7", mem_ready, 0);
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      if (acc_a) ai++;
      if (acc_m) mi++;
      tick();
    end
    idle();
    chk("cont_alu_accepted", ai, 13);
    chk("cont_mem_accepted", mi, 3);
    chk("cont_count_end", mq_count, 0);
    tick();

    // Reset mid-operation
    ld_issue = 1; ld_rd = 3;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h111;
    mem_valid = 1; mem_rd = 20; mem_data = 32'h2020;
    expq.push_back({5'd1, 32'h111});
    tick();
    ld_issue = 0;
    alu_data = 32'h222;
    mem_rd = 21; mem_data = 32'h2121;
    expq.push_back({5'd1, 32'h222});
    tick(); idle();
    rs1 = 3;
    #1;
    chk("mid_count", mq_count, 2);
    chk("mid_stall", stall, 1);
    chk("mid_mem_ready", mem_ready, 0);
    rst = 1;
    tick(); rst = 0;
    #1;
    chk("mid_rst_count", mq_count, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_we3", we3, 0);
    chk("mid_rst_mem_ready", mem_ready, 1);
    rs1 = 0;
    repeat (3) tick();
    chk("exp_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
